variable_chooser_n: RTL and testbench

Parametrised successor to the single-width variable chooser in the MCMC constraint-solver front end. It picks the next variable to resample, either uniformly at random via a configurable Galois LFSR with rejection sampling, or as a deterministic sequential sweep. It supports any mix of boolean and integer variable counts, including non-power-of-two totals. It drives the proposal stage through a valid/ready handshake, and supports a runtime seed reload with zero-seed protection.

---
 rtl/variable_chooser_n.sv | 112 +++++++++++
 tb/tb_variable_chooser_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/variable_chooser_n.sv
// Picks the next MCMC variable to resample, either randomly (Galois LFSR with
// rejection sampling) or as a sequential sweep, behind a valid/ready handshake.
`timescale 1ns/1ps
module variable_chooser_n #(
  parameter int unsigned            LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0]  TAPS         = LFSR_WIDTH'(16'hB400),
  parameter logic [LFSR_WIDTH-1:0]  SEED_DEFAULT = LFSR_WIDTH'(16'h0001),
  parameter int unsigned            NUM_BOOL     = 8,
  parameter int unsigned            NUM_INT      = 8,
  parameter int unsigned            INDEX_WIDTH  = 8
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_seed_load,
  input  logic [LFSR_WIDTH-1:0]  in_seed,
  input  logic                   in_mode,
  input  logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_boolean_or_integer,
  output logic [INDEX_WIDTH-1:0] out_choosen_index,
  output logic                   out_seed_error
);

  localparam int unsigned N         = NUM_BOOL + NUM_INT;
  localparam int unsigned SEL_WIDTH = (N > 1) ? $clog2(N) : 1;
  // One extra bit so N itself and the bool boundary are representable.
  localparam int unsigned CW        = SEL_WIDTH + 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                 state, state_d;
  logic [LFSR_WIDTH-1:0]  lfsr, lfsr_d;
  logic [SEL_WIDTH-1:0]   seq_cnt, seq_d;
  logic                   valid_d, type_d, err_d;
  logic [INDEX_WIDTH-1:0] idx_d;

  logic [LFSR_WIDTH-1:0]  lfsr_step;
  logic [SEL_WIDTH-1:0]   cand;
  logic [CW-1:0]          cand_w;
  logic [CW-1:0]          cand_idx;
  logic                   cand_ok;
  logic                   cand_bool;
  logic                   attempt;

  // Candidate generation, acceptance and type/index mapping.
  always_comb begin
    lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    cand      = in_mode ? seq_cnt : lfsr_step[SEL_WIDTH-1:0];
    cand_w    = {1'b0, cand};
    cand_ok   = in_mode || (cand_w < CW'(N));
    cand_bool = cand_w < CW'(NUM_BOOL);
    cand_idx  = cand_bool ? cand_w : cand_w - CW'(NUM_BOOL);
    attempt   = (state == FILL) || in_ready;
  end

  // Next-state and registered-output logic; seed load overrides any draw.
  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    seq_d   = seq_cnt;
    valid_d = out_valid;
    type_d  = out_boolean_or_integer;
    idx_d   = out_choosen_index;
    err_d   = out_seed_error;
    if (in_seed_load) begin
      if (in_seed != '0) begin
        lfsr_d  = in_seed;
        seq_d   = '0;
        valid_d = 1'b0;
        state_d = FILL;
        err_d   = 1'b0;
      end else begin
        err_d   = 1'b1;
      end
    end else if (attempt) begin
      lfsr_d = lfsr_step;
      if (cand_ok) begin
        valid_d = 1'b1;
        type_d  = cand_bool;
        idx_d   = INDEX_WIDTH'(cand_idx);
        state_d = HOLD;
        if (in_mode) begin
          seq_d = (seq_cnt == SEL_WIDTH'(N - 1)) ? '0 : seq_cnt + SEL_WIDTH'(1);
        end
      end else begin
        valid_d = 1'b0;
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state                  <= FILL;
      lfsr                   <= SEED_DEFAULT;
      seq_cnt                <= '0;
      out_valid              <= 1'b0;
      out_boolean_or_integer <= 1'b0;
      out_choosen_index      <= '0;
      out_seed_error         <= 1'b0;
    end else begin
      state                  <= state_d;
      lfsr                   <= lfsr_d;
      seq_cnt                <= seq_d;
      out_valid              <= valid_d;
      out_boolean_or_integer <= type_d;
      out_choosen_index      <= idx_d;
      out_seed_error         <= err_d;
    end
  end

endmodule

// File: tb/tb_variable_chooser_n.sv
// Scoreboard bench for variable_chooser_n (3 boolean + 2 integer variables):
// a transaction-level model predicts each choice, a monitor checks presentations.
`timescale 1ns/1ps
module tb_variable_chooser_n;

  localparam int NB   = 3;
  localparam int NI   = 2;
  localparam int N    = NB + NI;
  localparam int SELW = 3;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        in_reset = 1'b0;
  logic        in_seed_load = 1'b0;
  logic [15:0] in_seed = 16'h0;
  logic        in_mode = 1'b0;
  logic        in_ready = 1'b0;
  logic        out_valid;
  logic        out_boolean_or_integer;
  logic [3:0]  out_choosen_index;
  logic        out_seed_error;

  variable_chooser_n #(
    .LFSR_WIDTH(16), .TAPS(TAPS), .SEED_DEFAULT(16'h0001),
    .NUM_BOOL(NB), .NUM_INT(NI), .INDEX_WIDTH(4)
  ) dut (
    .in_clock(clk), .in_reset(in_reset), .in_seed_load(in_seed_load),
    .in_seed(in_seed), .in_mode(in_mode), .in_ready(in_ready),
    .out_valid(out_valid), .out_boolean_or_integer(out_boolean_or_integer),
    .out_choosen_index(out_choosen_index), .out_seed_error(out_seed_error)
  );

  always #5 clk = ~clk;

  typedef struct { bit typ; int idx; } choice_t;
  choice_t     exp_q[$];
  logic [15:0] m_lfsr = 16'h0001;
  int          m_seq = 0;
  bit          m_valid = 0;
  bit          m_err = 0;
  int          n_vec = 0;
  int          n_mis = 0;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
  endfunction

  // Drive one cycle of inputs and advance the reference model for the coming edge.
  task automatic step(bit ld, logic [15:0] sd, bit md, bit rdy);
    int      r;
    choice_t c;
    @(negedge clk);
    in_reset = 1'b0; in_seed_load = ld; in_seed = sd; in_mode = md; in_ready = rdy;
    if (ld) begin
      if (sd != 16'h0) begin
        m_lfsr = sd; m_seq = 0; m_valid = 0; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (!m_valid || rdy) begin
      m_lfsr = lfsr_next(m_lfsr);
      r = md ? m_seq : int'(m_lfsr) % (1 << SELW);
      if (r < N) begin
        c.typ = (r < NB);
        c.idx = (r < NB) ? r : r - NB;
        exp_q.push_back(c);
        m_valid = 1;
        if (md) m_seq = (m_seq + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_type"}, int'(out_boolean_or_integer), 0);
    chk({tag, "_index"}, int'(out_choosen_index), 0);
    chk({tag, "_seed_error"}, int'(out_seed_error), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    in_reset = 1'b1; in_seed_load = 1'b0; in_ready = 1'b0;
    #1;
    check_zero("async_reset");
    m_lfsr = 16'h0001; m_seq = 0; m_valid = 0; m_err = 0;
    exp_q.delete();
  endtask

  bit         prev_valid = 0;
  bit         prev_typ = 0;
  int         prev_idx = 0;

  // Monitor: compares each newly presented choice and checks held outputs stay put.
  always @(posedge clk) begin
    choice_t c;
    #1;
    if (in_reset) begin
      prev_valid = 0;
    end else begin
      chk("valid", int'(out_valid), int'(m_valid));
      chk("seed_error", int'(out_seed_error), int'(m_err));
      if (out_valid && (!prev_valid || in_ready)) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_mis++;
          $display("FAIL unexpected_choice: got type %0d index %0d, expected none",
                   out_boolean_or_integer, out_choosen_index);
        end else begin
          c = exp_q.pop_front();
          chk("choice_type", int'(out_boolean_or_integer), int'(c.typ));
          chk("choice_index", int'(out_choosen_index), c.idx);
        end
      end else if (out_valid && prev_valid) begin
        chk("held_type", int'(out_boolean_or_integer), int'(prev_typ));
        chk("held_index", int'(out_choosen_index), prev_idx);
      end
      prev_valid = out_valid;
      prev_typ   = out_boolean_or_integer;
      prev_idx   = int'(out_choosen_index);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ld, md, rdy;
    logic [15:0] sd;
    #1 in_reset = 1'b1;
    #1 check_zero("reset");

    // First draw from SEED_DEFAULT: 0x0001 -> 0xB400, r=0 -> bool 0.
    step(0, 16'h0, 0, 0); settle();
    chk("first_valid", int'(out_valid), 1);
    chk("first_type", int'(out_boolean_or_integer), 1);
    chk("first_index", int'(out_choosen_index), 0);

    // Seed 7 -> 0xB403, r=3 -> integer 0.
    step(1, 16'h0007, 0, 0); settle();
    chk("load_drops_valid", int'(out_valid), 0);
    step(0, 16'h0, 0, 1); settle();
    chk("seed7_valid", int'(out_valid), 1);
    chk("seed7_type", int'(out_boolean_or_integer), 0);
    chk("seed7_index", int'(out_choosen_index), 0);

    // Seed 0xF -> 0xB407 (r=7 rejected) -> 0xEE03 (r=3 -> integer 0).
    step(1, 16'h000F, 0, 0);
    step(0, 16'h0, 0, 0); settle();
    chk("reject_valid", int'(out_valid), 0);
    step(0, 16'h0, 0, 0); settle();
    chk("after_reject_valid", int'(out_valid), 1);
    chk("after_reject_type", int'(out_boolean_or_integer), 0);
    chk("after_reject_index", int'(out_choosen_index), 0);

    // Sequential sweep with a 3-cycle stall in the middle.
    step(1, 16'h0001, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 1);

    // Zero seed while holding, then a good seed clears the error.
    step(1, 16'h0000, 0, 0); settle();
    chk("zero_seed_error", int'(out_seed_error), 1);
    chk("zero_seed_valid_kept", int'(out_valid), 1);
    step(1, 16'h0001, 0, 0); settle();
    chk("good_seed_error_clear", int'(out_seed_error), 0);
    chk("good_seed_valid", int'(out_valid), 0);

    // Random-mode backpressure, then release.
    for (int i = 0; i < 30; i++) step(0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 16'h0, 0, 1);

    // Sticky error, then asynchronous reset mid-operation.
    step(1, 16'h0000, 0, 0);
    step(0, 16'h0, 1, 1);
    do_reset();
    step(0, 16'h0, 0, 0); settle();
    chk("post_midreset_type", int'(out_boolean_or_integer), 1);
    chk("post_midreset_index", int'(out_choosen_index), 0);

    // Randomised traffic: seed loads, mode flips, random ready.
    md = 0;
    for (int i = 0; i < 3000; i++) begin
      ld  = ($urandom_range(0, 31) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 15) == 0) md = ~md;
      rdy = ($urandom_range(0, 9) < 7);
      if (ld && sd == 16'h0000) rdy = 0;
      step(ld, sd, md, rdy);
    end

    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
